uart_baud_gen: RTL

Runtime-programmable UART baud/oversample tick generator and the parametrised successor of the fixed RX clock divider. It produces single-cycle enable ticks in the clk domain instead of a derived clock. A fractional accumulator holds baud error below one clock per oversample period. Tick phase can be resynchronised on a start-bit edge. It feeds the RX sampler (os_tick, mid_tick) and the TX shifter (bit_tick).

---
 rtl/uart_baud_pkg.sv | 36 +++
 rtl/uart_baud_gen_counter.sv | 60 ++++++
 rtl/uart_baud_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared defaults, divisor helper and
// transfer-source encoding for the UART tick generator.
package uart_baud_pkg;

    localparam int DEF_CLK_HZ = 25000000;
    localparam int DEF_BAUD   = 9600;
    localparam int DEF_OSR    = 16;
    localparam int DEF_DIV_W  = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int OSR_W      = $clog2(DEF_OSR);

    // Smallest integer divisor the counter can honour.
    localparam int MIN_DIV = 2;

    // Where the next active divisor comes from.
    typedef enum logic [1:0] {
        XF_NONE,
        XF_SHADOW,
        XF_INPUT
    } xfer_e;

    // Rounded fixed-point clocks per oversample period.
    function automatic longint unsigned rst_div(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned osr,
        input int              frac_w
    );
        longint unsigned num;
        longint unsigned den;
        num = clk_hz << frac_w;
        den = baud * osr;
        return (num + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen_counter.sv
// baud_frac_counter: period counter with fractional
// accumulator; emits one tick per oversample period.
module baud_frac_counter
    import uart_baud_pkg::*;
#(
    parameter int                DIV_W    = DEF_DIV_W,
    parameter int                FRAC_W   = DEF_FRAC_W,
    parameter logic [FRAC_W-1:0] RST_FRAC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic [FRAC_W-1:0] clr_frac,
    output logic              tick
);

    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;

    logic [DIV_W-1:0]  w_eff_int;
    logic [DIV_W:0]    w_last;
    logic [FRAC_W:0]   w_sum;

    // Clamp the divisor, find the last count of this
    // period; >= guards a divisor shrunk while held.
    always_comb begin
        w_eff_int = div_int;
        if (div_int < DIV_W'(MIN_DIV)) begin
            w_eff_int = DIV_W'(MIN_DIV);
        end
        w_last = {1'b0, w_eff_int}
               + {{DIV_W{1'b0}}, r_ext}
               - (DIV_W+1)'(1);
        w_sum  = {1'b0, r_acc} + {1'b0, div_frac};
        tick   = en && !clear && ({1'b0, r_cnt} >= w_last);
    end

    // Count, accumulate the fraction, restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= RST_FRAC;
            r_ext <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
            r_acc <= clr_frac;
            r_ext <= 1'b0;
        end else if (tick) begin
            r_cnt <= '0;
            {r_ext, r_acc} <= w_sum;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable oversample/bit tick
// generator with shadowed divisor and phase resync.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int DEF_BAUD = uart_baud_pkg::DEF_BAUD,
    parameter int OSR      = DEF_OSR,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int FRAC_W   = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    input  logic                    resync,
    output logic                    os_tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic [$clog2(OSR)-1:0]  os_idx,
    output logic                    cfg_pending,
    output logic                    cfg_err
);

    localparam int IDX_W = $clog2(OSR);

    localparam longint unsigned RST_DIV = rst_div(
        64'(CLK_HZ), 64'(DEF_BAUD), 64'(OSR), FRAC_W);

    localparam logic [DIV_W-1:0]  RST_INT  =
        DIV_W'(RST_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] RST_FRAC =
        FRAC_W'(RST_DIV);

    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OSR/2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OSR - 1);

    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pending;
    logic              r_cfg_err;
    logic [IDX_W-1:0]  r_idx;

    xfer_e             w_xfer;
    logic [DIV_W-1:0]  w_nxt_int;
    logic [FRAC_W-1:0] w_nxt_frac;
    logic              w_tick;

    // Pick the divisor that is active from next cycle on.
    always_comb begin
        w_xfer = XF_NONE;
        if (div_load && (resync || !en)) begin
            w_xfer = XF_INPUT;
        end else if (r_pending && (w_tick || resync || !en)) begin
            w_xfer = XF_SHADOW;
        end
        w_nxt_int  = r_act_int;
        w_nxt_frac = r_act_frac;
        unique case (w_xfer)
            XF_SHADOW: begin
                w_nxt_int  = r_sh_int;
                w_nxt_frac = r_sh_frac;
            end
            XF_INPUT: begin
                w_nxt_int  = div_int;
                w_nxt_frac = div_frac;
            end
            default: begin
                w_nxt_int  = r_act_int;
                w_nxt_frac = r_act_frac;
            end
        endcase
    end

    // Shadow capture, transfer to active and clamp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_int  <= RST_INT;
            r_act_frac <= RST_FRAC;
            r_sh_int   <= RST_INT;
            r_sh_frac  <= RST_FRAC;
            r_pending  <= 1'b0;
            r_cfg_err  <= (RST_INT < DIV_W'(MIN_DIV));
        end else begin
            if (w_xfer != XF_NONE) begin
                r_act_int  <= w_nxt_int;
                r_act_frac <= w_nxt_frac;
                r_cfg_err  <= (w_nxt_int < DIV_W'(MIN_DIV));
            end
            if (w_xfer == XF_SHADOW) begin
                r_pending <= 1'b0;
            end
            if (div_load) begin
                r_sh_int  <= div_int;
                r_sh_frac <= div_frac;
                r_pending <= (w_xfer != XF_INPUT);
            end
        end
    end

    // Oversample phase: advance per tick, zero on resync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (resync) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    baud_frac_counter #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .RST_FRAC (RST_FRAC)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clear    (resync),
        .div_int  (r_act_int),
        .div_frac (r_act_frac),
        .clr_frac (w_nxt_frac),
        .tick     (w_tick)
    );

    assign os_tick     = w_tick;
    assign mid_tick    = w_tick && (r_idx == IDX_MID);
    assign bit_tick    = w_tick && (r_idx == IDX_LAST);
    assign os_idx      = r_idx;
    assign cfg_pending = r_pending;
    assign cfg_err     = r_cfg_err;

endmodule
